grid_config_loader: RTL and testbench

- Parametrised configuration loader for the logic grid. It replaces the flat, externally driven grid config bus with a word-serial load path.
- Accepts configuration words over a valid/ready stream and assembles them column by column, column 0 first. Each column commits atomically.
- Drives the full grid config bus together with a config_valid qualifier.
- Sits between the bitstream source (SPI/JTAG front end) and the grid top.

---
 rtl/grid_config_loader_pkg.sv | 38 +++
 rtl/grid_config_loader_column_buffer.sv | 66 ++++++
 rtl/grid_config_loader.sv | 160 ++++++++++++++++
 tb/tb_grid_config_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_config_loader_pkg.sv
// rtl/grid_config_loader_pkg.sv - shared types, CRC constants and CRC helper for grid_config_loader
// Package grid_config_pkg; CRC helpers are only referenced when KFPGA_CONFIG_CRC_EN is defined.
package grid_config_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      DONE,
      ERROR
   } loader_state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // Widest config word the CRC helper can consume.
   localparam int CRC_MAX_WORD_WIDTH = 64;

   // CRC-16-CCITT over the low 'width' bits of 'word', most significant bit first.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                              input logic [CRC_MAX_WORD_WIDTH-1:0] word,
                                              input int width);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = CRC_MAX_WORD_WIDTH - 1; i >= 0; i--) begin
         if (i < width) begin
            fb = c[15] ^ word[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
               c = c ^ CRC16_POLY;
            end
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/grid_config_loader_column_buffer.sv
// rtl/grid_config_loader_column_buffer.sv - staging register and word counter for one grid column
// Module config_column_buffer: assembles WORDS_PER_COLUMN words, LSB word first, into one column.
module config_column_buffer #(
   parameter int COLUMN_CONFIG_WIDTH = 4192,
   parameter int WORD_WIDTH          = 32
) (
   input  logic                           clock,
   input  logic                           nreset,
   input  logic                           clear,
   input  logic                           word_fire,
   input  logic [WORD_WIDTH-1:0]          word_data,
   output logic                           column_done,
   output logic [COLUMN_CONFIG_WIDTH-1:0] column_data
);

   localparam int WORDS_PER_COLUMN = (COLUMN_CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int STAGE_WIDTH      = WORDS_PER_COLUMN * WORD_WIDTH;
   localparam int CNT_W            = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;

   logic [STAGE_WIDTH-1:0] staging_q, staging_d;
   logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
   logic                   last_word;
   logic [STAGE_WIDTH-1:0] merged;

   assign last_word = (word_cnt_q == CNT_W'(WORDS_PER_COLUMN - 1));

   // Merge the incoming word into its slot; the column is presented with the final word already in place
   // so the top can commit it on the same edge that accepts that word.
   always_comb begin
      merged = staging_q;
      for (int w = 0; w < WORDS_PER_COLUMN; w++) begin
         if (word_cnt_q == CNT_W'(w)) begin
            merged[w*WORD_WIDTH +: WORD_WIDTH] = word_data;
         end
      end
      column_done = word_fire && last_word;
      column_data = merged[COLUMN_CONFIG_WIDTH-1:0];

      staging_d  = staging_q;
      word_cnt_d = word_cnt_q;
      if (clear) begin
         staging_d  = '0;
         word_cnt_d = '0;
      end else if (word_fire) begin
         if (last_word) begin
            staging_d  = '0;
            word_cnt_d = '0;
         end else begin
            staging_d  = merged;
            word_cnt_d = word_cnt_q + 1'b1;
         end
      end
   end

   // Staging and counter registers.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         staging_q  <= '0;
         word_cnt_q <= '0;
      end else begin
         staging_q  <= staging_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: rtl/grid_config_loader.sv
// rtl/grid_config_loader.sv - word-serial configuration loader driving the logic grid config bus
// Optional trailing CRC-16 check word enabled by defining KFPGA_CONFIG_CRC_EN.
module grid_config_loader
   import grid_config_pkg::*;
#(
   parameter int NUM_COLUMNS         = 8,
   parameter int COLUMN_CONFIG_WIDTH = 4192,
   parameter int WORD_WIDTH          = 32
) (
   input  logic                                       clock,
   input  logic                                       nreset,
   input  logic                                       start,
   input  logic                                       word_valid,
   output logic                                       word_ready,
   input  logic [WORD_WIDTH-1:0]                      word_data,
   output logic [NUM_COLUMNS*COLUMN_CONFIG_WIDTH-1:0] config_out,
   output logic                                       config_valid,
   output logic                                       busy,
   output logic                                       error,
   output logic [$clog2(NUM_COLUMNS+1)-1:0]           column_index
);

   localparam int WORDS_PER_COLUMN = (COLUMN_CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int COL_W            = $clog2(NUM_COLUMNS + 1);
   localparam int CFG_W            = NUM_COLUMNS * COLUMN_CONFIG_WIDTH;

   loader_state_e            state_q, state_d;
   logic [CFG_W-1:0]         config_q, config_d;
   logic [COL_W-1:0]         col_idx_q, col_idx_d;
   logic                     config_valid_q, config_valid_d;
   logic                     busy_q, busy_d;
   logic                     error_q, error_d;
   logic                     word_ready_q, word_ready_d;

   logic                           xfer;
   logic                           load_fire;
   logic                           column_done;
   logic [COLUMN_CONFIG_WIDTH-1:0] column_data;

   // A start pulse wins over a coincident word, so that word never reaches the datapath.
   assign xfer      = word_valid && word_ready_q && !start;
   assign load_fire = xfer && (state_q == LOAD);

   config_column_buffer #(
      .COLUMN_CONFIG_WIDTH (COLUMN_CONFIG_WIDTH),
      .WORD_WIDTH          (WORD_WIDTH)
   ) u_column_buffer (
      .clock       (clock),
      .nreset      (nreset),
      .clear       (start),
      .word_fire   (load_fire),
      .word_data   (word_data),
      .column_done (column_done),
      .column_data (column_data)
   );

`ifdef KFPGA_CONFIG_CRC_EN
   logic [15:0]                   crc_q, crc_d;
   logic [CRC_MAX_WORD_WIDTH-1:0] word_ext;

   // Running CRC over every accepted data word, padding bits included.
   always_comb begin
      word_ext                   = '0;
      word_ext[WORD_WIDTH-1:0]   = word_data;
      crc_d                      = crc_q;
      if (start) begin
         crc_d = CRC16_INIT;
      end else if (load_fire) begin
         crc_d = crc16_word(crc_q, word_ext, WORD_WIDTH);
      end
   end

   // CRC accumulator register.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end
`endif

   // Next-state, column commit and next values of the registered outputs.
   always_comb begin
      state_d   = state_q;
      config_d  = config_q;
      col_idx_d = col_idx_q;
      if (start) begin
         state_d   = LOAD;
         config_d  = '0;
         col_idx_d = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (column_done) begin
                  for (int c = 0; c < NUM_COLUMNS; c++) begin
                     if (col_idx_q == COL_W'(c)) begin
                        config_d[c*COLUMN_CONFIG_WIDTH +: COLUMN_CONFIG_WIDTH] = column_data;
                     end
                  end
                  col_idx_d = col_idx_q + 1'b1;
                  if (col_idx_q == COL_W'(NUM_COLUMNS - 1)) begin
`ifdef KFPGA_CONFIG_CRC_EN
                     state_d = CHECK;
`else
                     state_d = DONE;
`endif
                  end
               end
            end
`ifdef KFPGA_CONFIG_CRC_EN
            CHECK: begin
               if (xfer) begin
                  state_d = (word_data[15:0] == crc_q) ? DONE : ERROR;
               end
            end
`endif
            default: state_d = state_q;
         endcase
      end

      busy_d         = (state_d == LOAD) || (state_d == CHECK);
      word_ready_d   = busy_d;
      config_valid_d = (state_d == DONE);
`ifdef KFPGA_CONFIG_CRC_EN
      error_d        = (state_d == ERROR);
`else
      error_d        = 1'b0;
`endif
   end

   // FSM state, output config register and registered status outputs.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q        <= IDLE;
         config_q       <= '0;
         col_idx_q      <= '0;
         config_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         error_q        <= 1'b0;
         word_ready_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         config_q       <= config_d;
         col_idx_q      <= col_idx_d;
         config_valid_q <= config_valid_d;
         busy_q         <= busy_d;
         error_q        <= error_d;
         word_ready_q   <= word_ready_d;
      end
   end

   assign config_out   = config_q;
   assign config_valid = config_valid_q;
   assign busy         = busy_q;
   assign error        = error_q;
   assign word_ready   = word_ready_q;
   assign column_index = col_idx_q;

endmodule

// File: tb/tb_grid_config_loader.sv
// tb/tb_grid_config_loader.sv - directed self-checking bench for grid_config_loader (KFPGA_CONFIG_CRC_EN aware)
module tb_grid_config_loader;

   localparam int NC  = 2;
   localparam int CCW = 40;
   localparam int WW  = 16;

   logic          clock;
   logic          nreset;
   logic          start;
   logic          word_valid;
   logic          word_ready;
   logic [WW-1:0] word_data;
   logic [NC*CCW-1:0] config_out;
   logic          config_valid;
   logic          busy;
   logic          error;
   logic [1:0]    column_index;

   int errors = 0;
   int checks = 0;

   localparam logic [79:0] EXP_A = 80'h6655554444_3322221111;
   localparam logic [79:0] EXP_B = 80'hFFEEEEDDDD_CCBBBBAAAA;

   logic [15:0] words_a [6];
   logic [15:0] words_b [6];

   grid_config_loader #(
      .NUM_COLUMNS         (NC),
      .COLUMN_CONFIG_WIDTH (CCW),
      .WORD_WIDTH          (WW)
   ) dut (
      .clock        (clock),
      .nreset       (nreset),
      .start        (start),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_data    (word_data),
      .config_out   (config_out),
      .config_valid (config_valid),
      .busy         (busy),
      .error        (error),
      .column_index (column_index)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [15:0] crc_model(input logic [15:0] w [6]);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = 0; k < 6; k++) begin
         for (int b = 15; b >= 0; b--) begin
            if (c[15] ^ w[k][b]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] d);
      int   budget;
      logic took;
      budget = 20;
      took   = 1'b0;
      while (!took && budget > 0) begin
         word_valid = 1'b1;
         word_data  = d;
         took       = word_ready;
         @(posedge clock);
         @(negedge clock);
         budget--;
      end
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL send_word_timeout: word %h not accepted, word_ready=%b expected 1", d, word_ready);
      end
   endtask

   task automatic load6(input logic [15:0] w [6], input bit gap);
      for (int k = 0; k < 6; k++) begin
         send_word(w[k]);
         if (gap) begin
            word_valid = 1'b0;
            word_data  = 16'hDEAD;
            @(negedge clock);
         end
      end
      word_valid = 1'b0;
   endtask

   task automatic load_full(input logic [15:0] w [6], input bit gap);
      load6(w, gap);
`ifdef KFPGA_CONFIG_CRC_EN
      send_word(crc_model(w));
      word_valid = 1'b0;
`endif
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (config_out !== '0) begin errors++; $display("FAIL reset_config_out: got %h expected 0", config_out); end
      checks++; if (config_valid !== 1'b0) begin errors++; $display("FAIL reset_config_valid: got %b expected 0", config_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
      checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready: got %b expected 0", word_ready); end
      checks++; if (column_index !== 2'd0) begin errors++; $display("FAIL reset_column_index: got %0d expected 0", column_index); end
      nreset = 1'b1;
      @(negedge clock);
      checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL idle_word_ready: got %b expected 0", word_ready); end
   endtask

   task automatic test_back_to_back();
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_after_start: got %b expected 1", busy); end
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_start: got %b expected 1", word_ready); end
      for (int k = 0; k < 5; k++) send_word(words_a[k]);
      checks++; if (config_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_early: got %b expected 0", config_valid); end
      checks++; if (config_out !== {40'h0, 40'h3322221111}) begin errors++; $display("FAIL b2b_partial: got %h expected %h", config_out, {40'h0, 40'h3322221111}); end
      send_word(words_a[5]);
      word_valid = 1'b0;
`ifdef KFPGA_CONFIG_CRC_EN
      checks++; if (config_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_before_crc: got %b expected 0", config_valid); end
      send_word(crc_model(words_a));
      word_valid = 1'b0;
`endif
      checks++; if (config_valid !== 1'b1) begin errors++; $display("FAIL b2b_config_valid: got %b expected 1", config_valid); end
      checks++; if (config_out !== EXP_A) begin errors++; $display("FAIL b2b_config_out: got %h expected %h", config_out, EXP_A); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_done: got %b expected 0", busy); end
      checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_done: got %b expected 0", word_ready); end
      checks++; if (column_index !== 2'd2) begin errors++; $display("FAIL b2b_column_index: got %0d expected 2", column_index); end
      repeat (3) @(negedge clock);
      checks++; if (config_out !== EXP_A || config_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %h/%b expected %h/1", config_out, config_valid, EXP_A); end
   endtask

   task automatic test_bubbles();
      pulse_start();
      checks++; if (config_out !== '0) begin errors++; $display("FAIL bub_cleared: got %h expected 0", config_out); end
      for (int k = 0; k < 3; k++) begin
         send_word(words_a[k]);
         word_valid = 1'b0;
         @(negedge clock);
      end
      checks++; if (config_out[39:0] !== 40'h3322221111) begin errors++; $display("FAIL bub_col0: got %h expected 3322221111", config_out[39:0]); end
      checks++; if (config_out[79:40] !== 40'h0) begin errors++; $display("FAIL bub_col1_zero: got %h expected 0", config_out[79:40]); end
      checks++; if (column_index !== 2'd1) begin errors++; $display("FAIL bub_column_index: got %0d expected 1", column_index); end
      for (int k = 3; k < 6; k++) begin
         checks++; if (config_valid !== 1'b0) begin errors++; $display("FAIL bub_valid_early: got %b expected 0 before word %0d", config_valid, k); end
         send_word(words_a[k]);
         word_valid = 1'b0;
         @(negedge clock);
      end
`ifdef KFPGA_CONFIG_CRC_EN
      send_word(crc_model(words_a));
      word_valid = 1'b0;
`endif
      checks++; if (config_valid !== 1'b1) begin errors++; $display("FAIL bub_config_valid: got %b expected 1", config_valid); end
      checks++; if (config_out !== EXP_A) begin errors++; $display("FAIL bub_config_out: got %h expected %h", config_out, EXP_A); end
   endtask

   task automatic test_abort();
      pulse_start();
      for (int k = 0; k < 4; k++) send_word(words_a[k]);
      word_valid = 1'b0;
      pulse_start();
      checks++; if (config_out !== '0) begin errors++; $display("FAIL abort_config_out: got %h expected 0", config_out); end
      checks++; if (column_index !== 2'd0) begin errors++; $display("FAIL abort_column_index: got %0d expected 0", column_index); end
      load_full(words_b, 1'b0);
      checks++; if (config_out !== EXP_B) begin errors++; $display("FAIL abort_reload: got %h expected %h", config_out, EXP_B); end
      checks++; if (config_valid !== 1'b1) begin errors++; $display("FAIL abort_valid: got %b expected 1", config_valid); end
   endtask

   task automatic test_async_reset();
      pulse_start();
      for (int k = 0; k < 4; k++) send_word(words_b[k]);
      word_valid = 1'b0;
      #2 nreset = 1'b0;
      #1;
      checks++; if (config_out !== '0) begin errors++; $display("FAIL areset_config_out: got %h expected 0", config_out); end
      checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL areset_word_ready: got %b expected 0", word_ready); end
      checks++; if (busy !== 1'b0 || column_index !== 2'd0) begin errors++; $display("FAIL areset_status: got busy=%b col=%0d expected 0/0", busy, column_index); end
      @(negedge clock);
      nreset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_start_in_done();
      pulse_start();
      load_full(words_a, 1'b0);
      start      = 1'b1;
      word_valid = 1'b1;
      word_data  = 16'h9999;
      @(posedge clock);
      @(negedge clock);
      start      = 1'b0;
      word_valid = 1'b0;
      checks++; if (config_valid !== 1'b0) begin errors++; $display("FAIL restart_valid: got %b expected 0", config_valid); end
      checks++; if (config_out !== '0) begin errors++; $display("FAIL restart_config_out: got %h expected 0", config_out); end
      checks++; if (column_index !== 2'd0 || word_ready !== 1'b1) begin errors++; $display("FAIL restart_status: got col=%0d ready=%b expected 0/1", column_index, word_ready); end
      load_full(words_a, 1'b0);
      checks++; if (config_out !== EXP_A) begin errors++; $display("FAIL restart_reload: got %h expected %h", config_out, EXP_A); end
   endtask

`ifdef KFPGA_CONFIG_CRC_EN
   task automatic test_crc();
      pulse_start();
      load6(words_b, 1'b0);
      checks++; if (busy !== 1'b1 || config_valid !== 1'b0) begin errors++; $display("FAIL crc_check_state: got busy=%b valid=%b expected 1/0", busy, config_valid); end
      send_word(crc_model(words_b));
      word_valid = 1'b0;
      checks++; if (config_valid !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL crc_good: got valid=%b err=%b expected 1/0", config_valid, error); end
      pulse_start();
      load6(words_b, 1'b0);
      send_word(crc_model(words_b) ^ 16'h0001);
      word_valid = 1'b0;
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL crc_bad_error: got %b expected 1", error); end
      checks++; if (config_valid !== 1'b0) begin errors++; $display("FAIL crc_bad_valid: got %b expected 0", config_valid); end
      checks++; if (config_out !== EXP_B) begin errors++; $display("FAIL crc_bad_keep: got %h expected %h", config_out, EXP_B); end
      repeat (3) @(negedge clock);
      checks++; if (word_ready !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL crc_bad_hold: got ready=%b err=%b expected 0/1", word_ready, error); end
      pulse_start();
      checks++; if (error !== 1'b0 || word_ready !== 1'b1) begin errors++; $display("FAIL crc_restart: got err=%b ready=%b expected 0/1", error, word_ready); end
   endtask
`endif

   initial begin
      words_a = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      words_b = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
      nreset     = 1'b0;
      start      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_abort();
      test_async_reset();
      test_start_in_done();
`ifdef KFPGA_CONFIG_CRC_EN
      test_crc();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
